dbus_sig_monitor: RTL and testbench
===================================

// Module: dbus_sig_monitor
// PURPOSE
//  Pass-through monitor on the core data port, between riscv_core (mem_d_*) and tcm_mem.
//  Captures accepted stores that hit a signature window into a FIFO, with a valid/ready drain port.
//  Tracks outstanding data requests.
//  Declares test completion when a marker store is accepted and all requests have been acked, or declares timeout.
//  Replaces the fixed-delay PC polling of result memory in the benches.
// PARAMETERS
//  SIG_BASE        32'h80009000  byte address of signature window (word aligned)
//  SIG_WORDS       64            window size in 32-bit words (power of 2, 2..1024)
//  MARKER_ADDR     32'h80009018  completion marker address (inside window)
//  MARKER_VALUE    32'hC0FFEE00  completion marker data
//  FIFO_DEPTH      8             capture FIFO entries (power of 2, >=2)
//  TIMEOUT_CYCLES  50000         cycles after reset release before TIMEOUT
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   synchronous active-high reset
//  cpu_*           in/out  --  core-side mem_d_* bundle: addr 32, data_wr 32, rd 1, wr 4, cacheable 1, req_tag 11, invalidate/writeback/flush 1; responses data_rd 32, accept 1, ack 1, error 1, resp_tag 11
//  mem_*           in/out  --  identical bundle toward tcm_mem; wired straight through, zero latency
//  sig_valid_o     out  1   FIFO head valid
//  sig_ready_i     in   1   consumer pops the head when valid&ready
//  sig_idx_o       out  log2(SIG_WORDS)  word index of captured store ((addr-SIG_BASE)>>2)
//  sig_data_o      out  32  captured store data, unmasked
//  sig_strb_o      out  4   captured byte enables (mem_d_wr)
//  done_o          out  1   in state DONE
//  timeout_o       out  1   in state TIMEOUT
//  overflow_o      out  1   sticky: a capture was dropped because the FIFO was full
//  proto_err_o     out  1   sticky: ack received with zero outstanding requests
//  cycle_count_o   out  32  cycles since reset release; frozen in DONE/TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, outstanding=0, cycle_count=0, state=RUN. Bus passthrough is unaffected by reset.
//  Request accepted: (cpu_rd | |cpu_wr) & mem_accept in the same cycle.
//  Capture: accepted request with |wr, addr in [SIG_BASE, SIG_BASE+4*SIG_WORDS), state RUN or FLUSH.
//   The entry is pushed at the clock edge and is visible on sig_* the next cycle.
//  FIFO: push and pop in the same cycle are both honoured, including when full; count is unchanged.
//   Push while full without pop: entry dropped, overflow_o set.
//   FIFO pointers wrap modulo FIFO_DEPTH.
//  Outstanding (width log2(FIFO_DEPTH)+2): +1 on accepted request, -1 on mem_ack, unchanged when both occur.
//   Ack at 0 without an accepted request that cycle: count stays 0, proto_err_o set.
//  cycle_count: increments every cycle in RUN/FLUSH.
//  FSM:
//   RUN -> FLUSH on accepted write with wr=4'hF, addr==MARKER_ADDR, data==MARKER_VALUE (the marker is also captured).
//   FLUSH -> DONE when outstanding==0, evaluated on the registered value (earliest the cycle after the marker ack).
//   RUN or FLUSH -> TIMEOUT when cycle_count==TIMEOUT_CYCLES-1; a marker in the same cycle wins (go to FLUSH).
//   DONE and TIMEOUT are terminal until reset; captures stop, the drain port still pops.
//  Partial-strobe write to MARKER_ADDR: captured, no state change.
//  Reset mid-operation: FIFO and flags cleared next edge; in-flight acks after reset count as proto_err only if they arrive once outstanding==0.
// TESTING
//  Stores 0xFFFFFFFF to SIG_BASE+0..+0x14, then the marker -> 7 FIFO entries with idx 0..6, then done_o; drained data matches.
//  Marker store with ack delayed 3 cycles -> done_o rises 1 cycle after the ack, not before.
//  10 window stores with sig_ready_i=0 -> 8 entries kept, overflow_o=1; push+pop when full keeps count at 8.
//  No marker -> timeout_o at cycle_count 49999; cycle_count_o frozen; done_o stays 0.
//  sb to MARKER_ADDR (wr=4'b0001) -> captured with strb 0x1; state stays RUN.
//  Spurious mem_ack after reset -> proto_err_o=1; rst_i pulse -> all flags 0, FIFO empty.

Source files
------------

// File: rtl/dbus_sig_monitor.sv
// Data-port monitor: zero-latency passthrough, signature capture FIFO,
// outstanding-request tracking and test-completion/timeout detection.
module dbus_sig_monitor #(
  parameter logic [31:0] SIG_BASE       = 32'h80009000,
  parameter int          SIG_WORDS      = 64,
  parameter logic [31:0] MARKER_ADDR    = 32'h80009018,
  parameter logic [31:0] MARKER_VALUE   = 32'hC0FFEE00,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 50000,
  localparam int         IW             = $clog2(SIG_WORDS),
  localparam int         PW             = $clog2(FIFO_DEPTH),
  localparam int         OW             = PW + 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [31:0]   cpu_data_wr_i,
  input  logic          cpu_rd_i,
  input  logic [3:0]    cpu_wr_i,
  input  logic          cpu_cacheable_i,
  input  logic [10:0]   cpu_req_tag_i,
  input  logic          cpu_invalidate_i,
  input  logic          cpu_writeback_i,
  input  logic          cpu_flush_i,
  output logic [31:0]   cpu_data_rd_o,
  output logic          cpu_accept_o,
  output logic          cpu_ack_o,
  output logic          cpu_error_o,
  output logic [10:0]   cpu_resp_tag_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_data_wr_o,
  output logic          mem_rd_o,
  output logic [3:0]    mem_wr_o,
  output logic          mem_cacheable_o,
  output logic [10:0]   mem_req_tag_o,
  output logic          mem_invalidate_o,
  output logic          mem_writeback_o,
  output logic          mem_flush_o,
  input  logic [31:0]   mem_data_rd_i,
  input  logic          mem_accept_i,
  input  logic          mem_ack_i,
  input  logic          mem_error_i,
  input  logic [10:0]   mem_resp_tag_i,
  output logic          sig_valid_o,
  input  logic          sig_ready_i,
  output logic [IW-1:0] sig_idx_o,
  output logic [31:0]   sig_data_o,
  output logic [3:0]    sig_strb_o,
  output logic          done_o,
  output logic          timeout_o,
  output logic          overflow_o,
  output logic          proto_err_o,
  output logic [31:0]   cycle_count_o
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE, TIMEOUT} state_t;

  localparam logic [31:0] WIN_BYTES = 32'(4 * SIG_WORDS);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [PW:0] DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  assign mem_addr_o       = cpu_addr_i;
  assign mem_data_wr_o    = cpu_data_wr_i;
  assign mem_rd_o         = cpu_rd_i;
  assign mem_wr_o         = cpu_wr_i;
  assign mem_cacheable_o  = cpu_cacheable_i;
  assign mem_req_tag_o    = cpu_req_tag_i;
  assign mem_invalidate_o = cpu_invalidate_i;
  assign mem_writeback_o  = cpu_writeback_i;
  assign mem_flush_o      = cpu_flush_i;
  assign cpu_data_rd_o    = mem_data_rd_i;
  assign cpu_accept_o     = mem_accept_i;
  assign cpu_ack_o        = mem_ack_i;
  assign cpu_error_o      = mem_error_i;
  assign cpu_resp_tag_o   = mem_resp_tag_i;

  state_t         state_q, state_d;
  logic [OW-1:0]  out_q;
  logic [31:0]    cyc_q;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    cnt_q;
  logic [IW-1:0]  fifo_idx  [FIFO_DEPTH];
  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic [3:0]     fifo_strb [FIFO_DEPTH];

  logic        acc, active, capture, marker, tmo_hit;
  logic        full, pop, push;
  logic [31:0] offs;

  assign acc     = (cpu_rd_i | (|cpu_wr_i)) & mem_accept_i;
  assign offs    = cpu_addr_i - SIG_BASE;
  assign active  = (state_q == RUN) || (state_q == FLUSH);
  assign capture = acc & (|cpu_wr_i) & (offs < WIN_BYTES) & active;
  assign marker  = acc && cpu_wr_i == 4'hF &&
                   cpu_addr_i == MARKER_ADDR &&
                   cpu_data_wr_i == MARKER_VALUE;
  assign tmo_hit = cyc_q == TMO_LAST;

  assign full        = cnt_q == DEPTH_C;
  assign sig_valid_o = cnt_q != '0;
  assign pop         = sig_valid_o & sig_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push        = capture & (~full | pop);

  assign sig_idx_o  = sig_valid_o ? fifo_idx[rd_ptr]  : '0;
  assign sig_data_o = sig_valid_o ? fifo_data[rd_ptr] : '0;
  assign sig_strb_o = sig_valid_o ? fifo_strb[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= offs[IW+1:2];
      fifo_data[wr_ptr] <= cpu_data_wr_i;
      fifo_strb[wr_ptr] <= cpu_wr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (capture && full && !pop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (acc && !mem_ack_i)
        out_q <= out_q + 1'b1;
      else if (!acc && mem_ack_i && out_q != '0)
        out_q <= out_q - 1'b1;
      if (mem_ack_i && !acc && out_q == '0) proto_err_o <= 1'b1;
    end
  end

  // Counter holds its final value on the edge that enters TIMEOUT
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cyc_q <= '0;
    else if (active && state_d != TIMEOUT)
      cyc_q <= cyc_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (marker)       state_d = FLUSH;
        else if (tmo_hit) state_d = TIMEOUT;
      end
      FLUSH: begin
        if (out_q == '0)  state_d = DONE;
        else if (tmo_hit) state_d = TIMEOUT;
      end
      DONE:    state_d = DONE;
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
  end

  assign done_o        = state_q == DONE;
  assign timeout_o     = state_q == TIMEOUT;
  assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_dbus_sig_monitor.sv
// Directed self-checking bench for dbus_sig_monitor.
// Drives the core side and plays the memory side by hand.
module tb_dbus_sig_monitor;

  localparam logic [31:0] BASE = 32'h80009000;
  localparam logic [31:0] MADR = 32'h80009018;
  localparam logic [31:0] MVAL = 32'hC0FFEE00;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] cpu_addr_i, cpu_data_wr_i;
  logic        cpu_rd_i;
  logic [3:0]  cpu_wr_i;
  logic        cpu_cacheable_i;
  logic [10:0] cpu_req_tag_i;
  logic        cpu_invalidate_i, cpu_writeback_i, cpu_flush_i;
  logic [31:0] cpu_data_rd_o;
  logic        cpu_accept_o, cpu_ack_o, cpu_error_o;
  logic [10:0] cpu_resp_tag_o;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic        mem_cacheable_o;
  logic [10:0] mem_req_tag_o;
  logic        mem_invalidate_o, mem_writeback_o, mem_flush_o;
  logic [31:0] mem_data_rd_i;
  logic        mem_accept_i, mem_ack_i, mem_error_i;
  logic [10:0] mem_resp_tag_i;
  logic        sig_valid_o, sig_ready_i;
  logic [5:0]  sig_idx_o;
  logic [31:0] sig_data_o;
  logic [3:0]  sig_strb_o;
  logic        done_o, timeout_o, overflow_o, proto_err_o;
  logic [31:0] cycle_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dbus_sig_monitor dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_wr_i(cpu_data_wr_i),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i),
    .cpu_cacheable_i(cpu_cacheable_i), .cpu_req_tag_i(cpu_req_tag_i),
    .cpu_invalidate_i(cpu_invalidate_i),
    .cpu_writeback_i(cpu_writeback_i), .cpu_flush_i(cpu_flush_i),
    .cpu_data_rd_o(cpu_data_rd_o), .cpu_accept_o(cpu_accept_o),
    .cpu_ack_o(cpu_ack_o), .cpu_error_o(cpu_error_o),
    .cpu_resp_tag_o(cpu_resp_tag_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_cacheable_o(mem_cacheable_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_invalidate_o(mem_invalidate_o),
    .mem_writeback_o(mem_writeback_o), .mem_flush_o(mem_flush_o),
    .mem_data_rd_i(mem_data_rd_i), .mem_accept_i(mem_accept_i),
    .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
    .mem_resp_tag_i(mem_resp_tag_i),
    .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i),
    .sig_idx_o(sig_idx_o), .sig_data_o(sig_data_o),
    .sig_strb_o(sig_strb_o), .done_o(done_o), .timeout_o(timeout_o),
    .overflow_o(overflow_o), .proto_err_o(proto_err_o),
    .cycle_count_o(cycle_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic ack);
    cpu_addr_i    = a;
    cpu_data_wr_i = d;
    cpu_wr_i      = w;
    mem_ack_i     = ack;
    step();
    cpu_wr_i  = 4'h0;
    mem_ack_i = 1'b0;
  endtask

  initial begin
    logic [31:0] cc;
    int n;
    rst_i = 1'b1;
    cpu_addr_i = '0; cpu_data_wr_i = '0; cpu_rd_i = 1'b0;
    cpu_wr_i = 4'h0; cpu_cacheable_i = 1'b0; cpu_req_tag_i = '0;
    cpu_invalidate_i = 1'b0; cpu_writeback_i = 1'b0; cpu_flush_i = 1'b0;
    mem_data_rd_i = 32'h12345678; mem_accept_i = 1'b1;
    mem_ack_i = 1'b0; mem_error_i = 1'b0; mem_resp_tag_i = 11'h5A5;
    sig_ready_i = 1'b0;

    // Reset state and passthrough
    do_reset();
    chk("rst_valid", 32'(sig_valid_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_proto", 32'(proto_err_o), 0);
    chk("rst_cycle", cycle_count_o, 0);
    step();
    chk("cycle_first", cycle_count_o, 1);
    cpu_addr_i = 32'hDEADBEEF;
    cpu_req_tag_i = 11'h3C3;
    #1;
    chk("pt_addr", mem_addr_o, 32'hDEADBEEF);
    chk("pt_tag", 32'(mem_req_tag_o), 32'h3C3);
    chk("pt_rdata", cpu_data_rd_o, 32'h12345678);
    chk("pt_rtag", 32'(cpu_resp_tag_o), 32'h5A5);
    cpu_req_tag_i = '0;

    // Six window stores plus the marker, then completion
    for (int i = 0; i < 6; i++) store(BASE + 32'(4 * i), 32'hFFFFFFFF, 4'hF, 1'b1);
    store(MADR, MVAL, 4'hF, 1'b1);
    chk("t1_flush_done", 32'(done_o), 0);
    step();
    chk("t1_done", 32'(done_o), 1);
    cc = cycle_count_o;
    sig_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t1_valid", 32'(sig_valid_o), 1);
      chk("t1_idx", 32'(sig_idx_o), 32'(i));
      chk("t1_data", sig_data_o, (i < 6) ? 32'hFFFFFFFF : MVAL);
      chk("t1_strb", 32'(sig_strb_o), 32'hF);
      step();
    end
    sig_ready_i = 1'b0;
    chk("t1_empty", 32'(sig_valid_o), 0);
    store(BASE, 32'h11, 4'hF, 1'b1);
    chk("t1_no_cap_done", 32'(sig_valid_o), 0);
    chk("t1_cycle_frozen", cycle_count_o, cc);
    chk("t1_done_stays", 32'(done_o), 1);

    // Marker with a late ack
    do_reset();
    store(MADR, MVAL, 4'hF, 1'b0);
    chk("t2_after_marker", 32'(done_o), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_wait", 32'(done_o), 0);
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("t2_ack_edge", 32'(done_o), 0);
    step();
    chk("t2_done", 32'(done_o), 1);
    chk("t2_idx", 32'(sig_idx_o), 6);
    chk("t2_strb", 32'(sig_strb_o), 32'hF);

    // Overflow and push+pop while full
    do_reset();
    for (int i = 0; i < 10; i++) store(BASE + 32'(4 * i), 32'(i), 4'hF, 1'b1);
    chk("t3_ovf", 32'(overflow_o), 1);
    chk("t3_head", 32'(sig_idx_o), 0);
    sig_ready_i = 1'b1;
    store(BASE + 32'd40, 32'hA, 4'hF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("t3_valid", 32'(sig_valid_o), 1);
      chk("t3_idx", 32'(sig_idx_o), (k < 7) ? 32'(k + 1) : 32'd10);
      chk("t3_data", sig_data_o, (k < 7) ? 32'(k + 1) : 32'hA);
      step();
    end
    sig_ready_i = 1'b0;
    chk("t3_empty", 32'(sig_valid_o), 0);
    chk("t3_proto", 32'(proto_err_o), 0);

    // Byte store to the marker address does not complete
    store(MADR, MVAL, 4'b0001, 1'b1);
    chk("t4_valid", 32'(sig_valid_o), 1);
    chk("t4_idx", 32'(sig_idx_o), 6);
    chk("t4_strb", 32'(sig_strb_o), 32'h1);
    chk("t4_data", sig_data_o, MVAL);
    step(); step(); step();
    chk("t4_run", 32'(done_o), 0);
    mem_accept_i = 1'b0;
    store(BASE, 32'h5, 4'hF, 1'b0);
    mem_accept_i = 1'b1;
    sig_ready_i = 1'b1;
    step();
    sig_ready_i = 1'b0;
    chk("t4_unaccepted", 32'(sig_valid_o), 0);
    store(MADR, MVAL, 4'hF, 1'b1);
    step();
    chk("t4_full_marker", 32'(done_o), 1);

    // Spurious ack, then reset pulse clears everything
    do_reset();
    chk("t5_ovf_cleared", 32'(overflow_o), 0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("t5_proto", 32'(proto_err_o), 1);
    store(MADR, MVAL, 4'hF, 1'b1);
    step();
    chk("t5_no_underflow", 32'(done_o), 1);
    do_reset();
    chk("t5_proto_clr", 32'(proto_err_o), 0);
    chk("t5_done_clr", 32'(done_o), 0);
    chk("t5_valid_clr", 32'(sig_valid_o), 0);
    chk("t5_cycle_clr", cycle_count_o, 0);

    // Timeout without a marker
    n = 0;
    while (!timeout_o && n < 60000) begin
      step();
      n++;
    end
    chk("t6_edges", 32'(n), 50000);
    chk("t6_timeout", 32'(timeout_o), 1);
    chk("t6_cycle", cycle_count_o, 49999);
    chk("t6_done", 32'(done_o), 0);
    step(); step(); step();
    chk("t6_frozen", cycle_count_o, 49999);
    store(BASE, 32'h7, 4'hF, 1'b1);
    chk("t6_no_cap", 32'(sig_valid_o), 0);
    chk("t6_stays", 32'(timeout_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
